// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared encodings and defaults for the HiLo multiply/divide unit
package hilo_pkg;

    localparam int HILO_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    // Op[1] selects the divider, Op[0] selects unsigned arithmetic.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/hilo_abs_neg.sv
// rtl/hilo_abs_neg.sv - combinational two's-complement conditional negate (abs when neg = sign bit)
module hilo_abs_neg #(
    parameter int N = 32
) (
    input  logic [N-1:0] value,
    input  logic         neg,
    output logic [N-1:0] result
);

    assign result = neg ? (~value + {{(N-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative MIPS-style HiLo multiply/divide unit; HILO_DIV_EN enables the divider
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [1:0]         Op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Busy,
    output logic               Done,
    output logic               HiLoWrite,
    output logic [2*WIDTH-1:0] HiLo
);

    localparam int CW = $clog2(WIDTH) + 1;

`ifdef HILO_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    state_e state, state_nx;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0] hi;         // partial product high half / partial remainder
    logic [WIDTH-1:0] lo;         // multiplier shifting out / quotient shifting in
    logic             sign_a;
    logic             sign_b;
    logic             no_write;   // completion without a result (divide disabled)

    logic             accept;
    logic             in_signed;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] hi_step, lo_step;
    logic [WIDTH:0]   acc;
    logic [2*WIDTH-1:0] prod_fix, result_fix;

    assign accept    = Start && (state == IDLE || state == DONE);
    assign in_signed = op_is_signed(Op);

    hilo_abs_neg #(.N(WIDTH)) u_abs_a (
        .value  (A),
        .neg    (in_signed & A[WIDTH-1]),
        .result (mag_a)
    );

    hilo_abs_neg #(.N(WIDTH)) u_abs_b (
        .value  (B),
        .neg    (in_signed & B[WIDTH-1]),
        .result (mag_b)
    );

    hilo_abs_neg #(.N(2*WIDTH)) u_fix_prod (
        .value  ({hi, lo}),
        .neg    (sign_a ^ sign_b),
        .result (prod_fix)
    );

    assign acc = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

`ifdef HILO_DIV_EN
    logic             div_q;
    logic             div0_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign shifted = {hi, lo[WIDTH-1]};
    assign fits    = shifted >= {1'b0, opnd};
    assign diff    = shifted[WIDTH-1:0] - opnd;

    hilo_abs_neg #(.N(WIDTH)) u_fix_quo (
        .value  (lo),
        .neg    (sign_a ^ sign_b),
        .result (quo_fix)
    );

    hilo_abs_neg #(.N(WIDTH)) u_fix_rem (
        .value  (hi),
        .neg    (sign_a),
        .result (rem_fix)
    );
`endif

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        hi_step = acc[WIDTH:1];
        lo_step = {acc[0], lo[WIDTH-1:1]};
`ifdef HILO_DIV_EN
        if (div_q) begin
            hi_step = fits ? diff : shifted[WIDTH-1:0];
            lo_step = {lo[WIDTH-2:0], fits};
        end
`endif
    end

    // Sign-corrected result presented during FIX; divide-by-zero bypasses the divider result.
    always_comb begin
        result_fix = prod_fix;
`ifdef HILO_DIV_EN
        if (div_q) begin
            result_fix = div0_q ? {a_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
        end
`endif
    end

    // Next-state and status outputs.
    always_comb begin
        state_nx  = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        HiLoWrite = 1'b0;
        case (state)
            IDLE: begin
                if (Start) state_nx = (op_is_div(Op) && !DIV_EN) ? DONE : RUN;
            end
            RUN: begin
                Busy = 1'b1;
                if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
            end
            FIX: begin
                Busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                Done      = 1'b1;
                HiLoWrite = ~no_write;
                if (Start) state_nx = (op_is_div(Op) && !DIV_EN) ? DONE : RUN;
                else       state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt      <= '0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            no_write <= 1'b0;
            HiLo     <= '0;
`ifdef HILO_DIV_EN
            div_q    <= 1'b0;
            div0_q   <= 1'b0;
            a_q      <= '0;
`endif
        end else begin
            if (accept) begin
                cnt      <= '0;
                hi       <= '0;
                opnd     <= op_is_div(Op) ? mag_b : mag_a;
                lo       <= op_is_div(Op) ? mag_a : mag_b;
                sign_a   <= in_signed & A[WIDTH-1];
                sign_b   <= in_signed & B[WIDTH-1];
                no_write <= op_is_div(Op) & ~DIV_EN;
`ifdef HILO_DIV_EN
                div_q    <= op_is_div(Op);
                div0_q   <= (B == '0);
                a_q      <= A;
`endif
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
                hi  <= hi_step;
                lo  <= lo_step;
            end
            if (state == FIX) HiLo <= result_fix;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - scoreboard bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    localparam int W = 32;

    logic           Clk = 1'b0;
    logic           Rst;
    logic           Start;
    logic [1:0]     Op;
    logic [W-1:0]   A, B;
    logic           Busy, Done, HiLoWrite;
    logic [2*W-1:0] HiLo;

    always #5 Clk = ~Clk;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .HiLoWrite (HiLoWrite),
        .HiLo      (HiLo)
    );

    typedef struct {
        logic [63:0] hilo;
        logic        write;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] last_hilo = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        longint      x, y;
        int          sa, sbv, q, rm;
        r = '0;
        case (op)
            OP_MULT: begin
                x = longint'($signed(a));
                y = longint'($signed(b));
                r = x * y;
            end
            OP_MULTU: r = {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    sa  = a;
                    sbv = b;
                    q   = sa / sbv;
                    rm  = sa % sbv;
                    r   = {rm, q};
                end
            end
            default: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else        r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit restart);
        exp_t e;
        int   lat;
        int   extra;
        bit   is_long;
        is_long = 1'b1;
`ifndef HILO_DIV_EN
        if (op[1]) is_long = 1'b0;
`endif
        e.write = is_long;
        e.lat   = is_long ? W + 2 : 1;
        e.hilo  = is_long ? model(op, a, b) : last_hilo;
        sb.push_back(e);
        Op = op; A = a; B = b; Start = 1'b1;
        lat = 0;
        do begin
            tick;
            lat++;
            if (lat == 1) begin
                Start = 1'b0;
                A  = $urandom;
                B  = $urandom;
                Op = 2'($urandom);
                check_eq({tag, "_busy"}, 64'(Busy), 64'(is_long));
            end
            if (restart && lat == 3) begin
                Op = OP_MULTU; A = 32'd9; B = 32'd11; Start = 1'b1;
            end
            if (restart && lat == 4) Start = 1'b0;
        end while (!Done && lat < 100);
        check_eq({tag, "_done_seen"}, 64'(Done), 64'd1);
        e = sb.pop_front();
        if (Done) begin
            check_eq({tag, "_latency"}, 64'(lat), 64'(e.lat));
            check_eq({tag, "_hilowrite"}, 64'(HiLoWrite), 64'(e.write));
            check_eq({tag, "_hilo"}, HiLo, e.hilo);
            last_hilo = e.hilo;
        end
        tick;
        check_eq({tag, "_done_pulse"}, 64'(Done), 64'd0);
        check_eq({tag, "_hilo_hold"}, HiLo, last_hilo);
        if (restart) begin
            extra = 0;
            repeat (40) begin
                tick;
                if (Done) extra++;
            end
            check_eq({tag, "_extra_done"}, 64'(extra), 64'd0);
        end
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int n;
        n = 0;
        repeat (cycles) begin
            tick;
            if (Done || HiLoWrite) n++;
        end
        check_eq(tag, 64'(n), 64'd0);
    endtask

    initial begin
        Rst = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
        repeat (2) tick;
        check_eq("rst_busy", 64'(Busy), 64'd0);
        check_eq("rst_done", 64'(Done), 64'd0);
        check_eq("rst_hilowrite", 64'(HiLoWrite), 64'd0);
        check_eq("rst_hilo", HiLo, 64'd0);
        Rst = 1'b0;
        tick;

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        run_op("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_op("mult_rand", 2'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
        end
        run_op("multu_restart", OP_MULTU, 32'd5, 32'd6, 1'b1);

`ifdef HILO_DIV_EN
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 1'b0);
        run_op("div_min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_zero_neg", OP_DIV, 32'hFFFF_FF00, 32'd0, 1'b0);
        run_op("div_negdiv", OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
        for (int i = 0; i < 2; i++) begin
            run_op("div_rand", 2'($urandom_range(2, 3)), $urandom, 32'($urandom_range(1, 100000)), 1'b0);
        end
        Op = OP_DIVU;
`else
        run_op("div_off", OP_DIV, 32'd100, 32'd3, 1'b0);
        run_op("divu_off", OP_DIVU, 32'd55, 32'd0, 1'b0);
        Op = OP_MULTU;
`endif

        A = 32'd1000; B = 32'd7; Start = 1'b1;
        tick;
        Start = 1'b0;
        repeat (10) tick;
        Rst = 1'b1;
        tick;
        Rst = 1'b0;
        check_eq("abort_busy", 64'(Busy), 64'd0);
        check_eq("abort_done", 64'(Done), 64'd0);
        check_eq("abort_hilowrite", 64'(HiLoWrite), 64'd0);
        check_eq("abort_hilo", HiLo, 64'd0);
        last_hilo = '0;
        watch_no_done("abort_no_done", 45);

        Rst = 1'b1; Start = 1'b1; Op = OP_MULTU; A = 32'd3; B = 32'd3;
        tick;
        Rst = 1'b0; Start = 1'b0;
        check_eq("rst_prio_busy", 64'(Busy), 64'd0);
        watch_no_done("rst_prio_no_done", 40);

        run_op("mult_after", OP_MULT, 32'd12345, 32'hFFFF_FFFE, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
